piano_play_ctrl: RTL



---
 rtl/piano_play_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/piano_play_ctrl.sv
// Auto-play step sequencer and live/auto note arbiter; all outputs registered, 1-cycle latency, no backpressure.
// Define AUTO_LOOP_EN to wrap the song at its last step instead of returning to IDLE.
module piano_play_ctrl #(
  parameter int unsigned SONG_LEN      = 33,
  parameter int unsigned HOLDOFF_BEATS = 4,
  parameter logic [3:0]  NOTE_NONE     = 4'd0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BEAT_TICK,
  input  logic       PLAY,
  input  logic       STOP,
  input  logic [3:0] manual_note,
  input  logic [3:0] auto_note,
  output logic [5:0] song_step,
  output logic [3:0] note_out,
  output logic       src_auto,
  output logic [1:0] play_state,
  output logic       song_done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_OVERRIDE = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(SONG_LEN - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_BEATS);

  state_t     state_q, state_d;
  logic [5:0] step_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] note_d;
  logic       src_d;
  logic       done_d;
  logic       key_held;

  assign key_held   = (manual_note != NOTE_NONE);
  assign play_state = state_q;

  always_comb begin
    state_d = state_q;
    step_d  = song_step;
    hold_d  = hold_q;
    note_d  = NOTE_NONE;
    src_d   = 1'b0;
    done_d  = 1'b0;

    if (STOP) begin
      state_d = S_IDLE;
      step_d  = 6'd0;
      hold_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Live keys pass through while idle; PLAY may start the song in the same cycle.
          note_d = manual_note;
          step_d = 6'd0;
          if (PLAY) state_d = S_PLAY;
        end

        S_PLAY: begin
          if (key_held) begin
            state_d = S_OVERRIDE;
            note_d  = manual_note;
          end else begin
            note_d = auto_note;
            src_d  = 1'b1;
            if (BEAT_TICK) begin
              if (song_step < LAST_STEP) begin
                step_d = song_step + 6'd1;
              end else begin
                step_d = 6'd0;
                done_d = 1'b1;
`ifndef AUTO_LOOP_EN
                state_d = S_IDLE;
`endif
              end
            end
          end
        end

        S_OVERRIDE: begin
          note_d = manual_note;
          if (!key_held) begin
            state_d = S_HOLDOFF;
            hold_d  = HOLD_LOAD;
          end
        end

        S_HOLDOFF: begin
          if (key_held) begin
            state_d = S_OVERRIDE;
            note_d  = manual_note;
          end else if (BEAT_TICK) begin
            // Resume on the tick that empties the counter; that tick does not advance the song.
            if (hold_q <= 4'd1) begin
              hold_d  = 4'd0;
              state_d = S_PLAY;
            end else begin
              hold_d = hold_q - 4'd1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          step_d  = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      song_step <= 6'd0;
      hold_q    <= 4'd0;
      note_out  <= NOTE_NONE;
      src_auto  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      song_step <= step_d;
      hold_q    <= hold_d;
      note_out  <= note_d;
      src_auto  <= src_d;
      song_done <= done_d;
    end
  end

endmodule
